// File: rtl/nano4k_flash_burst_reader_pkg.sv
// Shared definitions for the nano4k flash burst reader: flash command codes,
// boot-reset timing and the sequencer state encoding.
package nano4k_flash_burst_reader_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_FREAD = 8'h0B;
  localparam logic [7:0] CMD_RSTEN = 8'h66;
  localparam logic [7:0] CMD_RST   = 8'h99;
  localparam logic [7:0] CMD_PP    = 8'h02;

  localparam int unsigned BOOT_WAIT_CYCLES = 64;

  typedef enum logic [3:0] {
    IDLE,
    ISSUE,
    STREAM,
    GAP_PAUSE,
    GAP_END,
    BOOT_START,
    BOOT_RSTEN,
    BOOT_GAP,
    BOOT_RST,
    BOOT_WAIT
  } burstState_t;

  function automatic logic [21:0] nextWordAddr(input logic [21:0] addr);
    return addr + 22'd4;
  endfunction

endpackage

// File: rtl/nano4k_word_fifo.sv
// First-word-fall-through word FIFO; push and pop may coincide, even when full.
module nano4k_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPop;

  assign empty    = (count == '0);
  assign doPop    = pop && !empty;
  assign headData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push)  wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      case ({push, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nano4k_flash_burst_reader.sv
// Burst read sequencer for the nano4k SPI flash interface.
// FLASH_BOOT_RESET_EN: issue RSTEN/RST to the flash after reset before accepting requests.
module nano4k_flash_burst_reader
  import nano4k_flash_burst_reader_pkg::*;
#(
  parameter logic [7:0]  READ_CMD      = CMD_READ,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CS_GAP_CYCLES = 4,
  parameter int unsigned LEN_W         = 16
) (
  input  logic             interfaceClk,
  input  logic             reset,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [21:0]      reqAddress,
  input  logic [LEN_W-1:0] reqWords,
  output logic [31:0]      wordData,
  output logic             wordValid,
  input  logic             wordReady,
  output logic             busy,
  output logic             done,
  output logic             interfaceEnable_n,
  output logic [7:0]       fCommand,
  output logic [21:0]      fAddress,
  input  logic [7:0]       fData_RD,
  input  logic             RdDataValid
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] PAUSE_LEVEL  = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] RESUME_LEVEL = CW'(FIFO_DEPTH - 2);
  localparam logic [6:0]    GAP_LAST     = 7'(CS_GAP_CYCLES - 1);
  localparam logic [6:0]    BOOT_LAST    = 7'(BOOT_WAIT_CYCLES - 1);
`ifdef FLASH_BOOT_RESET_EN
  localparam burstState_t RESET_STATE = BOOT_START;
`else
  localparam burstState_t RESET_STATE = IDLE;
`endif

  burstState_t      state, stateNext;
  logic [2:0]       strobeSync;
  logic             byteEvent, streamByte;
  logic [1:0]       byteCnt;
  logic [23:0]      byteAcc;
  logic [21:0]      resumeAddr;
  logic [LEN_W-1:0] wordsLeft;
  logic [6:0]       gapCnt;
  logic             accept, lastWord;
  logic             fifoPush, fifoPop, fifoEmpty;
  logic [CW-1:0]    fifoCount, countAfterPush;

  assign byteEvent      = strobeSync[1] && !strobeSync[2];
  assign streamByte     = byteEvent && (state == STREAM);
  assign fifoPush       = streamByte && (byteCnt == 2'd3);
  assign fifoPop        = wordValid && wordReady;
  assign wordValid      = !fifoEmpty;
  assign accept         = reqValid && reqReady;
  assign lastWord       = (wordsLeft == LEN_W'(1));
  assign countAfterPush = fifoCount + CW'(1) - CW'(fifoPop);

  nano4k_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk      (interfaceClk),
    .reset    (reset),
    .push     (fifoPush),
    .pushData ({fData_RD, byteAcc}),
    .pop      (fifoPop),
    .headData (wordData),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_ff @(posedge interfaceClk) begin
    if (reset) state <= RESET_STATE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext         = state;
    reqReady          = 1'b0;
    busy              = 1'b1;
    interfaceEnable_n = 1'b1;
    fCommand          = READ_CMD;
    case (state)
      IDLE: begin
        reqReady = 1'b1;
        busy     = 1'b0;
        if (reqValid && reqWords != '0) stateNext = ISSUE;
      end
      ISSUE: begin
        interfaceEnable_n = 1'b0;
        stateNext         = STREAM;
      end
      STREAM: begin
        interfaceEnable_n = 1'b0;
        // the stream cannot stall, so stop while one slot of margin remains
        if (fifoPush) begin
          if (lastWord)                           stateNext = GAP_END;
          else if (countAfterPush >= PAUSE_LEVEL) stateNext = GAP_PAUSE;
        end
      end
      GAP_PAUSE: if (gapCnt >= GAP_LAST && fifoCount <= RESUME_LEVEL) stateNext = ISSUE;
      GAP_END:   if (gapCnt >= GAP_LAST) stateNext = IDLE;
      BOOT_START: stateNext = BOOT_RSTEN;
      BOOT_RSTEN: begin
        interfaceEnable_n = 1'b0;
        fCommand          = CMD_RSTEN;
        stateNext         = BOOT_GAP;
      end
      BOOT_GAP: if (gapCnt >= GAP_LAST) stateNext = BOOT_RST;
      BOOT_RST: begin
        interfaceEnable_n = 1'b0;
        fCommand          = CMD_RST;
        stateNext         = BOOT_WAIT;
      end
      BOOT_WAIT: if (gapCnt >= BOOT_LAST) stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  always_ff @(posedge interfaceClk) begin
    if (reset) begin
      strobeSync <= '0;
      byteCnt    <= '0;
      byteAcc    <= '0;
      resumeAddr <= '0;
      wordsLeft  <= '0;
      gapCnt     <= '0;
      fAddress   <= '0;
      done       <= 1'b0;
    end else begin
      strobeSync <= {strobeSync[1:0], RdDataValid};
      done       <= (accept && reqWords == '0) || (fifoPush && lastWord);

      if (accept) begin
        resumeAddr <= reqAddress;
        wordsLeft  <= reqWords;
      end else if (fifoPush) begin
        resumeAddr <= nextWordAddr(resumeAddr);
        wordsLeft  <= wordsLeft - LEN_W'(1);
      end

      if (streamByte) begin
        byteCnt <= byteCnt + 2'd1;
        case (byteCnt)
          2'd0:    byteAcc[7:0]   <= fData_RD;
          2'd1:    byteAcc[15:8]  <= fData_RD;
          2'd2:    byteAcc[23:16] <= fData_RD;
          default: byteAcc        <= byteAcc;
        endcase
      end else if (state != STREAM) begin
        byteCnt <= '0;
      end

      if (state != stateNext)  gapCnt <= '0;
      else if (gapCnt != '1)   gapCnt <= gapCnt + 7'd1;

      if (stateNext == ISSUE && state != ISSUE)
        fAddress <= (state == IDLE) ? reqAddress : resumeAddr;
    end
  end

endmodule

// File: tb/tb_nano4k_flash_burst_reader.sv
// Directed bench for nano4k_flash_burst_reader with a byte-stream flash model
// and an expected-word scoreboard; also covers FLASH_BOOT_RESET_EN builds.
module tb_nano4k_flash_burst_reader;

  localparam int unsigned DEPTH = 4;
`ifdef FLASH_BOOT_RESET_EN
  localparam bit BOOT = 1'b1;
`else
  localparam bit BOOT = 1'b0;
`endif

  logic        interfaceClk = 1'b0;
  logic        reset;
  logic        reqValid, reqReady;
  logic [21:0] reqAddress;
  logic [15:0] reqWords;
  logic [31:0] wordData;
  logic        wordValid, wordReady;
  logic        busy, done, interfaceEnable_n;
  logic [7:0]  fCommand;
  logic [21:0] fAddress;
  logic [7:0]  fData_RD;
  logic        RdDataValid;

  nano4k_flash_burst_reader #(
    .READ_CMD(8'h03), .FIFO_DEPTH(DEPTH), .CS_GAP_CYCLES(4), .LEN_W(16)
  ) dut (
    .interfaceClk(interfaceClk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddress(reqAddress), .reqWords(reqWords),
    .wordData(wordData), .wordValid(wordValid), .wordReady(wordReady),
    .busy(busy), .done(done), .interfaceEnable_n(interfaceEnable_n),
    .fCommand(fCommand), .fAddress(fAddress), .fData_RD(fData_RD), .RdDataValid(RdDataValid)
  );

  always #5 interfaceClk = ~interfaceClk;

  int          nCmp = 0;
  int          nFail = 0;
  int          doneSeen = 0;
  logic [31:0] expQ[$];
  logic [31:0] gotQ[$];
  logic [7:0]  issueCmd[$];
  logic [21:0] issueAddr[$];

  // Flash contents: every byte equals the low byte of its address.
  function automatic logic [31:0] flashWord(input logic [21:0] a);
    logic [31:0] w;
    logic [21:0] t;
    for (int unsigned k = 0; k < 4; k++) begin
      t = a + 22'(k);
      w[8*k +: 8] = t[7:0];
    end
    return w;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge interfaceClk);
  endtask

  task automatic request(input logic [21:0] a, input logic [15:0] w);
    int t = 0;
    while (!reqReady && t < 2000) begin tick(1); t++; end
    check("req_ready_wait", reqReady, 1);
    reqAddress = a;
    reqWords   = w;
    reqValid   = 1'b1;
    for (int unsigned i = 0; i < w; i++) expQ.push_back(flashWord(a + 22'(4 * i)));
    tick(1);
    reqValid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((expQ.size() != 0 || !reqReady) && t < 4000) begin tick(1); t++; end
    check(nm, expQ.size(), 0);
  endtask

  // Flash model: latch command/address at enable fall, then stream bytes until enable rises.
  initial begin
    logic [21:0] a;
    bit          alive;
    RdDataValid = 1'b0;
    fData_RD    = '0;
    forever begin
      @(negedge interfaceClk);
      if (!interfaceEnable_n && !reset) begin
        issueCmd.push_back(fCommand);
        issueAddr.push_back(fAddress);
        a     = fAddress;
        alive = 1'b1;
        for (int k = 0; k < 4 && alive; k++) begin
          @(negedge interfaceClk);
          if (interfaceEnable_n) alive = 1'b0;
        end
        while (alive) begin
          fData_RD    = a[7:0];
          RdDataValid = 1'b1;
          for (int k = 0; k < 6 && alive; k++) begin
            @(negedge interfaceClk);
            if (k == 2) RdDataValid = 1'b0;
            if (interfaceEnable_n) alive = 1'b0;
          end
          a = a + 22'd1;
        end
        RdDataValid = 1'b0;
      end
    end
  end

  // Compare process: every popped word against the scoreboard, done pulses, overflow guard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge interfaceClk);
      #1;
      if (!reset) begin
        if (done) doneSeen++;
        if (wordValid && wordReady) begin
          if (expQ.size() == 0) begin
            check("unexpected_word", wordData, 32'hDEAD_BEEF);
          end else begin
            e = expQ.pop_front();
            check("word_data", wordData, e);
          end
          gotQ.push_back(wordData);
        end
        if (dut.fifoPush && !(wordValid && wordReady))
          check("push_not_full", 32'(dut.fifoCount < 3'(DEPTH)), 1);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, i0, d0, t;
    reset = 1'b1; reqValid = 1'b0; reqAddress = '0; reqWords = '0; wordReady = 1'b1;
    tick(3);
    check("rst_reqReady", reqReady, !BOOT);
    check("rst_busy", busy, BOOT);
    check("rst_done", done, 0);
    check("rst_wordValid", wordValid, 0);
    check("rst_enable_n", interfaceEnable_n, 1);
    check("rst_fCommand", fCommand, 8'h03);
    check("rst_fAddress", fAddress, 0);
    check("rst_wordData", wordData, 0);
    reset = 1'b0;

    t = 0;
    while (!reqReady && t < 500) begin tick(1); t++; end
    check("boot_ready", reqReady, 1);
    check("boot_cmd_count", issueCmd.size(), BOOT ? 2 : 0);
`ifdef FLASH_BOOT_RESET_EN
    check("boot_rsten", issueCmd[0], 8'h66);
    check("boot_rst", issueCmd[1], 8'h99);
`endif

    // two words, consumer always ready
    g0 = gotQ.size(); i0 = issueAddr.size(); d0 = doneSeen;
    request(22'h000100, 16'd2);
    drain("t1_drain");
    check("t1_count", gotQ.size() - g0, 2);
    check("t1_word0", gotQ[g0], 32'h03020100);
    check("t1_word1", gotQ[g0 + 1], 32'h07060504);
    check("t1_done", doneSeen - d0, 1);
    check("t1_bursts", issueAddr.size() - i0, 1);
    check("t1_addr", issueAddr[i0], 22'h000100);
    check("t1_cmd", issueCmd[i0], 8'h03);

    // eight words with a stalled consumer: pause after three, resume at +12
    wordReady = 1'b0;
    g0 = gotQ.size(); i0 = issueAddr.size(); d0 = doneSeen;
    request(22'h000040, 16'd8);
    tick(99);
    check("t2_paused_bursts", issueAddr.size() - i0, 1);
    check("t2_paused_enable", interfaceEnable_n, 1);
    check("t2_paused_valid", wordValid, 1);
    wordReady = 1'b1;
    drain("t2_drain");
    check("t2_count", gotQ.size() - g0, 8);
    check("t2_word3", gotQ[g0 + 3], 32'h4F4E4D4C);
    check("t2_bursts", issueAddr.size() - i0, 2);
    check("t2_resume_addr", issueAddr[i0 + 1], 22'h00004C);
    check("t2_done", doneSeen - d0, 1);

    // address wrap across a forced pause
    wordReady = 1'b0;
    g0 = gotQ.size(); d0 = doneSeen;
    request(22'h000200, 16'd2);
    t = 0;
    while (doneSeen == d0 && t < 1000) begin tick(1); t++; end
    check("t3_fill_done", doneSeen - d0, 1);
    i0 = issueAddr.size(); d0 = doneSeen;
    request(22'h3FFFFC, 16'd2);
    tick(80);
    check("t3_paused_bursts", issueAddr.size() - i0, 1);
    check("t3_first_addr", issueAddr[i0], 22'h3FFFFC);
    wordReady = 1'b1;
    drain("t3_drain");
    check("t3_bursts", issueAddr.size() - i0, 2);
    check("t3_wrap_addr", issueAddr[i0 + 1], 22'h000000);
    check("t3_word_hi", gotQ[g0 + 2], 32'hFFFEFDFC);
    check("t3_word_wrap", gotQ[g0 + 3], 32'h03020100);
    check("t3_done", doneSeen - d0, 1);

    // zero-word request
    i0 = issueAddr.size(); d0 = doneSeen;
    request(22'h000123, 16'd0);
    check("t4_done_pulse", done, 1);
    tick(1);
    check("t4_done_low", done, 0);
    tick(20);
    check("t4_no_burst", issueAddr.size() - i0, 0);
    check("t4_done_count", doneSeen - d0, 1);
    check("t4_ready", reqReady, 1);

    // reset in the middle of a stream
    request(22'h000080, 16'd8);
    tick(40);
    check("t5_streaming", interfaceEnable_n, 0);
    reset = 1'b1;
    expQ.delete();
    tick(1);
    check("t5_enable_n", interfaceEnable_n, 1);
    check("t5_wordValid", wordValid, 0);
    check("t5_reqReady", reqReady, !BOOT);
    reset = 1'b0;

    // fresh request after the reset
    g0 = gotQ.size(); d0 = doneSeen;
    request(22'h000010, 16'd3);
    i0 = issueAddr.size() - 1;
    drain("t6_drain");
    check("t6_count", gotQ.size() - g0, 3);
    check("t6_word0", gotQ[g0], 32'h13121110);
    check("t6_word2", gotQ[g0 + 2], 32'h1B1A1918);
    check("t6_addr", issueAddr[i0], 22'h000010);
    check("t6_done", doneSeen - d0, 1);

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
